multi_button_debouncer: RTL
===========================

// Module: multi_button_debouncer
// PURPOSE
// - N-channel debouncer for player buttons (paddle up/down, serve, pause) in the pingpong design.
// - Per channel: 2-FF synchroniser, debounce counter, stable level, press/release pulses.
// - Adds hold-to-repeat pulses and a long-press flag, so paddle logic moves on a held key.
// - Sits between board pins and game control logic; all outputs are in the clk domain.
// PARAMETERS
// - N_CH           4       number of independent button channels
// - CNT_WIDTH      16      debounce counter width; input must be stable 2**CNT_WIDTH cycles
// - UNPUSHED_STATE '0      [N_CH-1:0] released pin level per channel (mixed polarity allowed)
// - RPT_WIDTH      24      width of the repeat timer
// - RPT_DELAY      24'd5_000_000  cycles from press pulse to first repeat pulse (>=2)
// - RPT_PERIOD     24'd1_000_000  cycles between subsequent repeat pulses (>=2)
// PORTS
// - clk          in   1     system clock
// - arst_n       in   1     asynchronous active-low reset
// - sw_i         in   N_CH  raw asynchronous button pins
// - rpt_en_i     in   N_CH  per-channel repeat enable (sync to clk)
// - sw_state_o   out  N_CH  debounced level, 1 = pressed (polarity normalised)
// - sw_down_o    out  N_CH  1-cycle pulse on debounced press
// - sw_up_o      out  N_CH  1-cycle pulse on debounced release
// - sw_rpt_o     out  N_CH  1-cycle pulse per auto-repeat event
// - sw_long_o    out  N_CH  level: held at least RPT_DELAY cycles since press
// BEHAVIOUR
// - Reset: reset is asynchronous (arst_n, active-low) on clk; sync FFs <= UNPUSHED_STATE[ch]; counters 0;
//   FSM RPT_IDLE; every output 0.
// - Sync: sync[1:0] <= {sync[0], sw_i[ch]}; pressed_raw = sync[1] ^ UNPUSHED_STATE[ch].
// - Debounce: while pressed_raw != sw_state_o: cnt++; when cnt is all-ones, toggle sw_state_o and
//   clear cnt. Any cycle with pressed_raw == sw_state_o: cnt <= 0 (glitch < 2**CNT_WIDTH rejected).
// - Latency: pin edge held stable -> sw_state_o changes 2 + 2**CNT_WIDTH cycles later.
// - sw_down_o/sw_up_o registered: high exactly in first cycle sw_state_o shows new level.
// - Repeat FSM per channel (rtmr = RPT_WIDTH-bit timer):
//   RPT_IDLE:   on press toggle -> RPT_DELAY, rtmr <= 0.
//   RPT_DELAY:  rtmr++; at rtmr == RPT_DELAY-1 -> RPT_REPEAT, rtmr <= 0, sw_long_o <= 1,
//               sw_rpt_o pulse if rpt_en_i[ch].
//   RPT_REPEAT: rtmr++; at rtmr == RPT_PERIOD-1 -> rtmr <= 0, sw_rpt_o pulse if rpt_en_i[ch].
//   Release toggle in any state -> RPT_IDLE, rtmr <= 0, sw_long_o <= 0, same cycle as sw_up_o.
// - Release toggle coinciding with a repeat terminal count: release wins, no sw_rpt_o.
// - rpt_en_i low only masks sw_rpt_o; FSM, timer and sw_long_o still run.
// - sw_rpt_o never coincides with sw_down_o (RPT_DELAY >= 2).
// - rtmr never wraps: cleared at terminal count; RPT_DELAY/RPT_PERIOD < 2**RPT_WIDTH.
// - Channels fully independent; simultaneous events on several channels all reported same cycle.
// - arst_n mid-press: all state cleared; after release of reset a held button needs a full
//   debounce window before sw_down_o.
// STRUCTURE
// - Package btn_pkg: typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_e;
//   shared default timing constants.
// - Sub-module btn_channel: one channel (sync, debounce, repeat FSM); top is a generate loop
//   over N_CH plus parameter slicing of UNPUSHED_STATE.
// TESTING  (sim params: N_CH=2, CNT_WIDTH=3, RPT_DELAY=20, RPT_PERIOD=6, UNPUSHED_STATE=2'b10)
// - Reset: arst_n low with sw_i=2'b10 -> all outputs 0; release, hold 50 cycles -> outputs stay 0.
// - Clean press ch0: sw_i[0] 0->1 at cycle 0 -> sw_state_o[0]=1 and sw_down_o[0]=1 at cycle 10,
//   sw_down_o low at cycle 11.
// - Glitch: sw_i[0] high for 5 cycles then low -> no state change, no pulses.
// - Hold ch1 (active-low) with rpt_en_i=2'b10: sw_down_o[1] then sw_rpt_o[1]+sw_long_o[1] 20 cycles
//   later, then sw_rpt_o every 6 cycles; release -> sw_up_o[1], sw_long_o[1]=0, no further rpt.
// - rpt_en_i[0]=0 hold ch0 40 cycles -> sw_long_o[0]=1, sw_rpt_o[0] never pulses.
// - Both channels pressed same cycle; arst_n pulse while held -> outputs 0, down re-issued after
//   window.

Source files
------------

// File: rtl/multi_button_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared types and default timing constants for the multi-channel button
// debouncer (pingpong player controls).
//   rpt_state_e      : per-channel hold-to-repeat FSM state
//   DEF_*            : default parameter values for a 50 MHz-class clock
// ---------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam int          DEF_N_CH       = 4;
  localparam int          DEF_CNT_WIDTH  = 16;
  localparam int          DEF_RPT_WIDTH  = 24;
  localparam logic [23:0] DEF_RPT_DELAY  = 24'd5_000_000;
  localparam logic [23:0] DEF_RPT_PERIOD = 24'd1_000_000;

endpackage

// File: rtl/multi_button_debouncer_if.sv
// ---------------------------------------------------------------------------
// multi_button_debouncer_if
// Bundles the per-channel button signals of the debouncer.
//   sw_i        raw asynchronous button pins
//   rpt_en_i    per-channel auto-repeat enable (clk domain)
//   sw_state_o  debounced level, 1 = pressed
//   sw_down_o   1-cycle press pulse
//   sw_up_o     1-cycle release pulse
//   sw_rpt_o    1-cycle auto-repeat pulse
//   sw_long_o   long-press level
//   rpt_state   repeat FSM state per channel (observation only)
// Signalling: there is no valid/ready handshake. sw_state_o and sw_long_o
// are levels valid every cycle; sw_down_o, sw_up_o and sw_rpt_o are
// single-cycle event strobes that the consumer must sample on the clock edge
// following the cycle in which they are high; there is no back-pressure.
// master: the side that drives the pins (board / testbench)
// slave : the debouncer
// ---------------------------------------------------------------------------
interface multi_button_debouncer_if
  import btn_pkg::*;
#(
  parameter int N_CH = DEF_N_CH
);

  logic [N_CH-1:0]       sw_i;
  logic [N_CH-1:0]       rpt_en_i;
  logic [N_CH-1:0]       sw_state_o;
  logic [N_CH-1:0]       sw_down_o;
  logic [N_CH-1:0]       sw_up_o;
  logic [N_CH-1:0]       sw_rpt_o;
  logic [N_CH-1:0]       sw_long_o;
  rpt_state_e [N_CH-1:0] rpt_state;

  modport master (
    output sw_i,
    output rpt_en_i,
    input  sw_state_o,
    input  sw_down_o,
    input  sw_up_o,
    input  sw_rpt_o,
    input  sw_long_o,
    input  rpt_state
  );

  modport slave (
    input  sw_i,
    input  rpt_en_i,
    output sw_state_o,
    output sw_down_o,
    output sw_up_o,
    output sw_rpt_o,
    output sw_long_o,
    output rpt_state
  );

endinterface

// File: rtl/multi_button_debouncer_channel.sv
// ---------------------------------------------------------------------------
// btn_channel
// One button channel: 2-FF synchroniser, debounce counter, press/release
// strobes and the hold-to-repeat FSM.
// Ports:
//   clk, arst_n   clock, asynchronous active-low reset
//   pin           raw asynchronous pin
//   rpt_en        repeat enable (masks rpt only)
//   state         debounced level, 1 = pressed
//   down, up      1-cycle press / release strobes
//   rpt           1-cycle auto-repeat strobe
//   long_press    held at least RPT_DELAY cycles since the press strobe
//   rpt_state     repeat FSM state (observation)
// ---------------------------------------------------------------------------
module btn_channel #(
  parameter int                   CNT_WIDTH  = btn_pkg::DEF_CNT_WIDTH,
  parameter int                   RPT_WIDTH  = btn_pkg::DEF_RPT_WIDTH,
  parameter logic [RPT_WIDTH-1:0] RPT_DELAY  = RPT_WIDTH'(btn_pkg::DEF_RPT_DELAY),
  parameter logic [RPT_WIDTH-1:0] RPT_PERIOD = RPT_WIDTH'(btn_pkg::DEF_RPT_PERIOD),
  parameter logic                 UNPUSHED   = 1'b0
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                pin,
  input  logic                rpt_en,
  output logic                state,
  output logic                down,
  output logic                up,
  output logic                rpt,
  output logic                long_press,
  output btn_pkg::rpt_state_e rpt_state
);

  import btn_pkg::*;

  // Terminal counts: the timer runs 0..N-1, so N cycles per interval.
  localparam logic [RPT_WIDTH-1:0] DELAY_LAST  = RPT_DELAY - 1'b1;
  localparam logic [RPT_WIDTH-1:0] PERIOD_LAST = RPT_PERIOD - 1'b1;

  logic [1:0]           sync;
  logic                 pressed_raw;
  logic [CNT_WIDTH-1:0] cnt;
  logic [RPT_WIDTH-1:0] rtmr;
  logic                 toggle;
  logic                 press_evt;
  logic                 release_evt;

  // Polarity normalised: 1 means the button is physically pushed.
  assign pressed_raw = sync[1] ^ UNPUSHED;

  // The debounced level flips on the cycle the counter has seen 2**CNT_WIDTH
  // consecutive disagreeing samples.
  assign toggle      = (pressed_raw != state) && (&cnt);
  assign press_evt   = toggle && !state;
  assign release_evt = toggle && state;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync <= {UNPUSHED, UNPUSHED};
    end else begin
      sync <= {sync[0], pin};
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt   <= '0;
      state <= 1'b0;
      down  <= 1'b0;
      up    <= 1'b0;
    end else begin
      down <= press_evt;
      up   <= release_evt;
      if (pressed_raw == state) begin
        // Any agreeing sample discards the partial window.
        cnt <= '0;
      end else if (&cnt) begin
        cnt   <= '0;
        state <= ~state;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Hold-to-repeat FSM. A release strobe overrides everything, including a
  // coinciding terminal count, so no repeat can follow a release.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rpt_state  <= RPT_IDLE;
      rtmr       <= '0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
    end else begin
      rpt <= 1'b0;
      if (release_evt) begin
        rpt_state  <= RPT_IDLE;
        rtmr       <= '0;
        long_press <= 1'b0;
      end else begin
        case (rpt_state)
          RPT_IDLE: begin
            if (press_evt) begin
              rpt_state <= btn_pkg::RPT_DELAY;
              rtmr      <= '0;
            end
          end
          btn_pkg::RPT_DELAY: begin
            if (rtmr == DELAY_LAST) begin
              rpt_state  <= RPT_REPEAT;
              rtmr       <= '0;
              long_press <= 1'b1;
              rpt        <= rpt_en;
            end else begin
              rtmr <= rtmr + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (rtmr == PERIOD_LAST) begin
              rtmr <= '0;
              rpt  <= rpt_en;
            end else begin
              rtmr <= rtmr + 1'b1;
            end
          end
          default: begin
            rpt_state  <= RPT_IDLE;
            rtmr       <= '0;
            long_press <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_button_debouncer.sv
// ---------------------------------------------------------------------------
// multi_button_debouncer
// N-channel button debouncer with press/release strobes, hold-to-repeat
// strobes and a long-press flag. All outputs are in the clk domain.
// Ports:
//   clk      system clock
//   arst_n   asynchronous active-low reset
//   bus      multi_button_debouncer_if.slave (pins in, debounced events out)
// Parameters:
//   N_CH, CNT_WIDTH, UNPUSHED_STATE (released pin level per channel),
//   RPT_WIDTH, RPT_DELAY (>=2), RPT_PERIOD (>=2)
// ---------------------------------------------------------------------------
module multi_button_debouncer #(
  parameter int                   N_CH           = btn_pkg::DEF_N_CH,
  parameter int                   CNT_WIDTH      = btn_pkg::DEF_CNT_WIDTH,
  parameter logic [N_CH-1:0]      UNPUSHED_STATE = '0,
  parameter int                   RPT_WIDTH      = btn_pkg::DEF_RPT_WIDTH,
  parameter logic [RPT_WIDTH-1:0] RPT_DELAY      = RPT_WIDTH'(btn_pkg::DEF_RPT_DELAY),
  parameter logic [RPT_WIDTH-1:0] RPT_PERIOD     = RPT_WIDTH'(btn_pkg::DEF_RPT_PERIOD)
) (
  input  logic                     clk,
  input  logic                     arst_n,
  multi_button_debouncer_if.slave  bus
);

  // Channels are fully independent; each gets its own released-level bit.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    btn_channel #(
      .CNT_WIDTH  (CNT_WIDTH),
      .RPT_WIDTH  (RPT_WIDTH),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD),
      .UNPUSHED   (UNPUSHED_STATE[ch])
    ) u_ch (
      .clk        (clk),
      .arst_n     (arst_n),
      .pin        (bus.sw_i[ch]),
      .rpt_en     (bus.rpt_en_i[ch]),
      .state      (bus.sw_state_o[ch]),
      .down       (bus.sw_down_o[ch]),
      .up         (bus.sw_up_o[ch]),
      .rpt        (bus.sw_rpt_o[ch]),
      .long_press (bus.sw_long_o[ch]),
      .rpt_state  (bus.rpt_state[ch])
    );
  end

endmodule
